// File: rtl/dsk_upload_pkg.sv
// Shared types and constants for the DSK image upload path (SDRAM -> I/O controller).
package dsk_upload_pkg;

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned ADDR_W = 25;
  localparam logic [ADDR_W-1:0] FDD_BASE = 25'h200000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } upl_state_t;

endpackage

// File: rtl/dsk_upload_byte_fifo.sv
// First-word-fall-through byte FIFO with synchronous flush; dout is the current head.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  // Flush overrides any same-cycle push or pop.
  always_comb begin
    do_push   = push & ~full & ~flush;
    do_pop    = pop & ~empty & ~flush;
    count_nxt = count + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= din;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/dsk_upload.sv
// Reads the floppy image back out of SDRAM through the misc port and streams it to the
// I/O controller upload handshake, prefetching into a small FIFO to hide memory latency.
module dsk_upload
  import dsk_upload_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE  = FDD_BASE,
  parameter int unsigned       DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  size,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [7:0]        mem_din,
  output logic              up_valid,
  output logic [7:0]        up_data,
  input  logic              up_ack
);

  localparam int unsigned FC_W = $clog2(DEPTH) + 1;

  upl_state_t        state, state_nxt;
  logic [CNT_W-1:0]  size_q, size_nxt;
  logic [CNT_W-1:0]  rd_cnt, rd_nxt;
  logic [CNT_W-1:0]  tx_cnt, tx_nxt;
  logic              pend, pend_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              rd_req_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  logic              push_c;
  logic              pop_c;
  logic              flush_c;
  logic [FC_W-1:0]   occ_c;
  logic [FC_W-1:0]   fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .flush   (flush_c),
    .push    (push_c),
    .pop     (pop_c),
    .din     (mem_din),
    .dout    (up_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign up_valid = ~fifo_empty;

  // Data returns only count while a read is outstanding in RUN; DRAIN discards them.
  assign push_c = (state == RUN) & pend & mem_ready & ~fifo_full;
  assign pop_c  = (state == RUN) & up_ack & up_valid;
  assign occ_c  = fifo_count - FC_W'(pop_c);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      size_q   <= '0;
      rd_cnt   <= '0;
      tx_cnt   <= '0;
      pend     <= 1'b0;
      mem_addr <= BASE;
      mem_rd   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      size_q   <= size_nxt;
      rd_cnt   <= rd_nxt;
      tx_cnt   <= tx_nxt;
      pend     <= pend_nxt;
      mem_addr <= addr_nxt;
      mem_rd   <= rd_req_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state, counters and read issue; the first read is issued straight from IDLE
  // so it appears together with busy.
  always_comb begin
    state_nxt  = state;
    size_nxt   = size_q;
    rd_nxt     = rd_cnt;
    tx_nxt     = tx_cnt;
    pend_nxt   = pend;
    addr_nxt   = mem_addr;
    rd_req_nxt = 1'b0;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    flush_c    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (size == '0) begin
            done_nxt = 1'b1;
          end else begin
            size_nxt   = size;
            tx_nxt     = '0;
            flush_c    = 1'b1;
            state_nxt  = RUN;
            busy_nxt   = 1'b1;
            rd_req_nxt = 1'b1;
            addr_nxt   = BASE;
            rd_nxt     = CNT_W'(1);
            pend_nxt   = 1'b1;
          end
        end
      end

      RUN: begin
        if (pop_c) begin
          tx_nxt = tx_cnt + CNT_W'(1);
        end
        if (push_c) begin
          pend_nxt = 1'b0;
        end
        if (pop_c && ((tx_cnt + CNT_W'(1)) == size_q)) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (abort) begin
          flush_c = 1'b1;
          if (pend && !mem_ready) begin
            state_nxt = DRAIN;
          end else begin
            pend_nxt  = 1'b0;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end else if (!pend && (rd_cnt < size_q) && (occ_c < FC_W'(DEPTH))) begin
          rd_req_nxt = 1'b1;
          addr_nxt   = BASE + ADDR_W'(rd_cnt);
          rd_nxt     = rd_cnt + CNT_W'(1);
          pend_nxt   = 1'b1;
        end
      end

      DRAIN: begin
        if (mem_ready) begin
          pend_nxt  = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        pend_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dsk_upload.sv
// Directed/randomized bench for dsk_upload: SDRAM responder with random latency and a
// reference image; every uploaded byte and read address is checked against the image.
module tb_dsk_upload;
  import dsk_upload_pkg::*;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  size;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ready;
  logic [7:0]        mem_din;
  logic              up_valid;
  logic [7:0]        up_data;
  logic              up_ack;

  logic [7:0]        img [256];
  logic [ADDR_W-1:0] addr_q [$];
  int                lat = 1;
  int                n_chk = 0;
  int                n_pass = 0;
  int                n_fail = 0;

  dsk_upload #(
    .BASE  (FDD_BASE),
    .DEPTH (4)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .size      (size),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_ready (mem_ready),
    .mem_din   (mem_din),
    .up_valid  (up_valid),
    .up_data   (up_data),
    .up_ack    (up_ack)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM model: logs each read and answers after `lat` cycles with the image byte.
  initial begin
    int                wait_cnt;
    logic [ADDR_W-1:0] pend_addr;
    wait_cnt  = 0;
    pend_addr = '0;
    mem_ready = 1'b0;
    mem_din   = 8'h00;
    forever begin
      @(negedge clk_sys);
      mem_ready = 1'b0;
      mem_din   = 8'($urandom);
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          mem_ready = 1'b1;
          mem_din   = img[8'(pend_addr - FDD_BASE)];
        end
      end
      if (mem_rd === 1'b1) begin
        addr_q.push_back(mem_addr);
        pend_addr = mem_addr;
        wait_cnt  = lat;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic do_start(input int n);
    size  = CNT_W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Consume until byte n has been acked; checks every byte, then done/busy timing.
  task automatic consume(input int n, input int first, input int prob, input bit spur,
                         input bit restart, input string tag);
    int got;
    int c;
    bit early_done;
    got = first;
    c = 0;
    early_done = 1'b0;
    while (got < n && c < 3000) begin
      if (done === 1'b1) early_done = 1'b1;
      up_ack = 1'b0;
      if (up_valid === 1'b1 && int'($urandom_range(99)) < prob) begin
        chk({tag, "_data"}, 32'(up_data), 32'(img[8'(got)]));
        got++;
        up_ack = 1'b1;
      end else if (up_valid !== 1'b1 && spur && $urandom_range(3) == 0) begin
        up_ack = 1'b1;
      end
      if (restart && c == 2) begin
        start = 1'b1;
        size  = CNT_W'(7);
      end
      step();
      up_ack = 1'b0;
      start  = 1'b0;
      c++;
    end
    chk({tag, "_count"}, 32'(got), 32'(n));
    chk({tag, "_early_done"}, 32'(early_done), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic chk_addrs(input int b, input int n, input string tag);
    chk({tag, "_nrd"}, 32'(addr_q.size() - b), 32'(n));
    for (int i = 0; i < n && (b + i) < addr_q.size(); i++) begin
      chk({tag, "_addr"}, 32'(addr_q[b + i]), 32'(FDD_BASE + ADDR_W'(i)));
    end
  endtask

  initial begin
    int b;
    int n;
    bit seen;
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    img[0] = 8'hAA;
    img[1] = 8'hBB;
    img[2] = 8'hCC;
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    up_ack = 1'b0;
    size   = '0;

    // Reset values
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'(FDD_BASE));
    chk("rst_up_valid", 32'(up_valid), 32'd0);
    chk("rst_up_data", 32'(up_data), 32'd0);
    step();
    reset = 1'b0;
    step();

    // Basic transfer AA,BB,CC acked as soon as valid
    lat = 2;
    b = addr_q.size();
    do_start(3);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_first_rd", 32'(mem_rd), 32'd1);
    consume(3, 0, 100, 1'b0, 1'b0, "basic");
    chk_addrs(b, 3, "basic");

    // Zero size: single done pulse, no busy, no reads
    b = addr_q.size();
    do_start(0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    step();
    chk("zero_done_pulse", 32'(done), 32'd0);
    chk("zero_busy2", 32'(busy), 32'd0);
    step();
    chk("zero_nrd", 32'(addr_q.size() - b), 32'd0);

    // Backpressure: 4 prefetched reads then stall until one ack
    lat = 2;
    b = addr_q.size();
    do_start(10);
    for (int c = 0; c < 40; c++) step();
    chk("bp_nrd_stall", 32'(addr_q.size() - b), 32'd4);
    chk("bp_valid", 32'(up_valid), 32'd1);
    chk("bp_head", 32'(up_data), 32'(img[0]));
    chk("bp_busy", 32'(busy), 32'd1);
    up_ack = 1'b1;
    step();
    up_ack = 1'b0;
    chk("bp_head1", 32'(up_data), 32'(img[1]));
    chk("bp_fifth_rd", 32'(mem_rd), 32'd1);
    chk("bp_fifth_addr", 32'(mem_addr), 32'(FDD_BASE + 25'd4));
    consume(10, 1, 60, 1'b0, 1'b0, "bp");
    chk_addrs(b, 10, "bp");

    // Abort with the second read outstanding
    lat = 8;
    b = addr_q.size();
    do_start(6);
    for (int c = 0; c < 60 && up_valid !== 1'b1; c++) step();
    chk("ab_first_byte", 32'(up_valid), 32'd1);
    for (int c = 0; c < 60 && mem_rd !== 1'b1; c++) step();
    chk("ab_second_rd", 32'(mem_rd), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_valid_drop", 32'(up_valid), 32'd0);
    chk("ab_busy_drain", 32'(busy), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 30 && mem_ready !== 1'b1; c++) begin
      if (done === 1'b1) seen = 1'b1;
      step();
    end
    chk("ab_late_ready", 32'(mem_ready), 32'd1);
    chk("ab_busy_fall", 32'(busy), 32'd0);
    chk("ab_valid_late", 32'(up_valid), 32'd0);
    step();
    chk("ab_valid_after", 32'(up_valid), 32'd0);
    chk("ab_no_done", 32'(seen | done), 32'd0);
    chk("ab_nrd", 32'(addr_q.size() - b), 32'd2);
    lat = 3;
    b = addr_q.size();
    do_start(5);
    chk("ab_restart_addr", 32'(mem_addr), 32'(FDD_BASE));
    consume(5, 0, 100, 1'b0, 1'b0, "ab_rerun");
    chk_addrs(b, 5, "ab_rerun");

    // Asynchronous reset between mem_rd and mem_ready
    lat = 6;
    do_start(8);
    chk("rs_rd", 32'(mem_rd), 32'd1);
    #4;
    reset = 1'b1;
    #1;
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_mem_rd", 32'(mem_rd), 32'd0);
    chk("rs_mem_addr", 32'(mem_addr), 32'(FDD_BASE));
    chk("rs_up_valid", 32'(up_valid), 32'd0);
    chk("rs_up_data", 32'(up_data), 32'd0);
    step();
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (up_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
      step();
    end
    chk("rs_stray_ignored", 32'(seen), 32'd0);

    // Restart while busy plus spurious acks, 5 bytes
    lat = 2;
    b = addr_q.size();
    do_start(5);
    consume(5, 0, 50, 1'b1, 1'b1, "dup");
    chk_addrs(b, 5, "dup");

    // Randomized transfers
    for (int t = 0; t < 3; t++) begin
      lat = int'($urandom_range(1, 4));
      n   = int'($urandom_range(1, 24));
      b   = addr_q.size();
      do_start(n);
      chk("rnd_busy", 32'(busy), 32'd1);
      consume(n, 0, int'($urandom_range(30, 100)), 1'b1, 1'b1, "rnd");
      chk_addrs(b, n, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
